// File: rtl/nabp_filter_pkg.sv
// rtl/nabp_filter_pkg.sv - shared state type, kernel coefficients and helpers for the projection filter
package nabp_filter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2
    } filt_state_e;

    // Ram-Lak kernel for 7 taps in Q.11, round-to-nearest; symmetric so tap order is immaterial
    localparam int RAMP_COEF [7] = '{-23, 0, -208, 512, -208, 0, -23};

    function automatic int half_of(input int taps);
        return (taps - 1) / 2;
    endfunction

endpackage

// File: rtl/nabp_projection_filter_if.sv
// rtl/nabp_projection_filter_if.sv - sample-in / filtered-out bundle of the projection filter
interface nabp_projection_filter_if #(
    parameter int DATA_WIDTH  = 12,
    parameter int OUT_WIDTH   = 16,
    parameter int LINE_LENGTH = 16
);
    localparam int S_W = $clog2(LINE_LENGTH);

    logic                        in_valid;
    logic                        in_first;
    logic [DATA_WIDTH-1:0]       in_data;
    logic                        in_ready;
    logic                        out_valid;
    logic [S_W-1:0]              out_s;
    logic                        out_last;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        busy;
    logic                        err;

    modport master (
        output in_valid, in_first, in_data,
        input  in_ready, out_valid, out_s, out_last, out_data, busy, err
    );

    modport slave (
        input  in_valid, in_first, in_data,
        output in_ready, out_valid, out_s, out_last, out_data, busy, err
    );

endinterface

// File: rtl/nabp_fir_mac.sv
// rtl/nabp_fir_mac.sv - tap shift register and 3-stage multiply / add / round-saturate pipeline
module nabp_fir_mac
    import nabp_filter_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int OUT_WIDTH  = 16,
    parameter int COEF_WIDTH = 12,
    parameter int COEF_FRAC  = 11,
    parameter int TAPS       = 7,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        shift_en,
    input  logic                        clear_taps,
    input  logic                        flush_pipe,
    input  logic                        emit,
    input  logic [DATA_WIDTH-1:0]       sample,
    input  logic [TAG_WIDTH-1:0]        tag,
    output logic                        out_valid,
    output logic [TAG_WIDTH-1:0]        out_tag,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        busy
);
    localparam int PROD_W = DATA_WIDTH + 1 + COEF_WIDTH;
    localparam int SUM_W  = PROD_W + $clog2(TAPS);
    localparam logic signed [SUM_W-1:0] ROUND_BIAS = SUM_W'(2 ** (COEF_FRAC - 1));
    localparam logic signed [SUM_W-1:0] SAT_MAX    = SUM_W'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN    = -SAT_MAX - SUM_W'(1);

    logic [DATA_WIDTH-1:0]       taps_q [TAPS];
    logic [DATA_WIDTH-1:0]       taps_d [TAPS];
    logic signed [PROD_W-1:0]    prod_q [TAPS];
    logic signed [PROD_W-1:0]    prod_d [TAPS];
    logic signed [SUM_W-1:0]     sum_q, sum_d, rounded;
    logic signed [OUT_WIDTH-1:0] data_q, data_d, sat;
    logic [TAG_WIDTH-1:0]        tag0_q, tag0_d, tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
    logic                        v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

    always_comb begin
        taps_d = taps_q;
        if (shift_en) begin
            for (int i = TAPS - 1; i > 0; i--) begin
                taps_d[i] = clear_taps ? '0 : taps_q[i-1];
            end
            taps_d[0] = sample;
        end

        for (int i = 0; i < TAPS; i++) begin
            prod_d[i] = PROD_W'($signed({1'b0, taps_q[i]})) * PROD_W'(RAMP_COEF[i]);
        end

        sum_d = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum_d = sum_d + SUM_W'(prod_q[i]);
        end

        // round half up: bias then floor via arithmetic shift
        rounded = (sum_q + ROUND_BIAS) >>> COEF_FRAC;
        if (rounded > SAT_MAX) begin
            sat = OUT_WIDTH'(SAT_MAX);
        end else if (rounded < SAT_MIN) begin
            sat = OUT_WIDTH'(SAT_MIN);
        end else begin
            sat = OUT_WIDTH'(rounded);
        end

        data_d = data_q;
        tag3_d = tag3_q;
        if (v2_q) begin
            data_d = sat;
            tag3_d = tag2_q;
        end

        // an abort kills everything already in flight; the new line's first shift never emits
        v0_d   = emit;
        v1_d   = v0_q & ~flush_pipe;
        v2_d   = v1_q & ~flush_pipe;
        v3_d   = v2_q & ~flush_pipe;
        tag0_d = emit ? tag : tag0_q;
        tag1_d = tag0_q;
        tag2_d = tag1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                taps_q[i] <= '0;
                prod_q[i] <= '0;
            end
            sum_q  <= '0;
            data_q <= '0;
            tag0_q <= '0;
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
        end else begin
            taps_q <= taps_d;
            prod_q <= prod_d;
            sum_q  <= sum_d;
            data_q <= data_d;
            tag0_q <= tag0_d;
            tag1_q <= tag1_d;
            tag2_q <= tag2_d;
            tag3_q <= tag3_d;
            v0_q   <= v0_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
        end
    end

    assign out_valid = v3_q;
    assign out_tag   = tag3_q;
    assign out_data  = data_q;
    assign busy      = v0_q | v1_q | v2_q | v3_q;

endmodule

// File: rtl/nabp_projection_filter.sv
// rtl/nabp_projection_filter.sv - streaming ramp FIR over one projection line with edge zero padding
module nabp_projection_filter
    import nabp_filter_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int OUT_WIDTH   = 16,
    parameter int COEF_WIDTH  = 12,
    parameter int COEF_FRAC   = 11,
    parameter int TAPS        = 7,
    parameter int LINE_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    nabp_projection_filter_if.slave bus
);
    localparam int HALF = half_of(TAPS);
    localparam int S_W  = $clog2(LINE_LENGTH);
    localparam int K_W  = $clog2(LINE_LENGTH + HALF + 1);

    filt_state_e                 state_q, state_d;
    logic [K_W-1:0]              k_q, k_d;
    logic                        err_q, err_d;
    logic                        in_ready, accept;
    logic                        shift_en, clear_taps, flush_pipe, emit;
    logic [DATA_WIDTH-1:0]       sample;
    logic [S_W-1:0]              tag;
    logic                        mac_valid, mac_busy;
    logic [S_W-1:0]              mac_tag;
    logic signed [OUT_WIDTH-1:0] mac_data;

    // k counts shift events of the current line (accepts plus trailing zero injections)
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        err_d      = 1'b0;
        shift_en   = 1'b0;
        clear_taps = 1'b0;
        flush_pipe = 1'b0;
        sample     = bus.in_data;
        in_ready   = (state_q != ST_FLUSH);
        accept     = bus.in_valid && in_ready;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.in_first) begin
                        clear_taps = 1'b1;
                        shift_en   = 1'b1;
                        k_d        = K_W'(1);
                        state_d    = ST_FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (accept) begin
                    shift_en = 1'b1;
                    if (bus.in_first) begin
                        err_d      = 1'b1;
                        flush_pipe = 1'b1;
                        clear_taps = 1'b1;
                        k_d        = K_W'(1);
                    end else begin
                        k_d = k_q + K_W'(1);
                        if (k_d == K_W'(LINE_LENGTH)) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                shift_en = 1'b1;
                sample   = '0;
                k_d      = k_q + K_W'(1);
                if (k_d == K_W'(LINE_LENGTH + HALF)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        emit = shift_en && (k_d > K_W'(HALF));
        tag  = S_W'(k_d - K_W'(HALF + 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

    nabp_fir_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .COEF_FRAC  (COEF_FRAC),
        .TAPS       (TAPS),
        .TAG_WIDTH  (S_W)
    ) u_mac (
        .clk        (clk),
        .reset      (reset),
        .shift_en   (shift_en),
        .clear_taps (clear_taps),
        .flush_pipe (flush_pipe),
        .emit       (emit),
        .sample     (sample),
        .tag        (tag),
        .out_valid  (mac_valid),
        .out_tag    (mac_tag),
        .out_data   (mac_data),
        .busy       (mac_busy)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = mac_valid;
    assign bus.out_s     = mac_tag;
    assign bus.out_last  = mac_valid && (mac_tag == S_W'(LINE_LENGTH - 1));
    assign bus.out_data  = mac_data;
    assign bus.busy      = (state_q != ST_IDLE) || mac_busy;
    assign bus.err       = err_q;

endmodule
